secure_reg_requester: RTL and testbench
=======================================

Name: secure_reg_requester

Overview:
- Initiator side of the thread-gated secure register interface.
- Accepts thread-tagged read/write requests from a core-side valid/ready port and drives the register's access_en/wr_en/thread_id/data_in signals.
- Captures read data after a fixed latency and returns a response with an error flag.
- Checks privilege locally: requests from non-zero threads never reach the register, are answered with an error, and are counted.

Parameters:
DATA_WIDTH, 32, width of register data and of request/response data
TID_WIDTH, 32, width of thread id fields
RD_LATENCY, 1, cycles from the issue cycle (reg_access_en high) to reg_data_out being valid; legal range 1..15
CNT_WIDTH, 16, width of the saturating denied-request counter

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_wr  input  1  1 = write, 0 = read
req_tid  input  TID_WIDTH  requesting thread id
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  output  1  1 = access denied
reg_access_en  output  1  register access strobe, one cycle per access
reg_wr_en  output  1  register write enable
reg_thread_id  output  TID_WIDTH  thread id presented to register
reg_data_in  output  DATA_WIDTH  write data to register
reg_data_out  input  DATA_WIDTH  read data from register
denied_cnt  output  CNT_WIDTH  saturating count of denied requests

Behaviour:
- Reset (rst high at posedge):
  - FSM goes to IDLE.
  - All outputs are 0, except req_ready, which is combinational (1 in IDLE).
  - denied_cnt is cleared.
  - Reset wins over every other event, including an accepted request or a response in flight. An in-flight response is dropped, not delivered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - req_ready = 1 only in IDLE. One outstanding request at a time.
- IDLE, on accept:
  - Latch wr, tid, wdata.
  - If tid == 0, go to ISSUE.
  - Otherwise go to RESP with rsp_err = 1 and rsp_rdata = 0, and increment denied_cnt (holds at all-ones).
  - No reg_* strobe is issued for a denied request.
- ISSUE (exactly one cycle):
  - reg_access_en = 1; reg_wr_en = latched wr; reg_thread_id = latched tid (always 0); reg_data_in = latched wdata.
  - Write: go to RESP with rsp_err = 0 and rsp_rdata = 0.
  - Read: load the latency counter with RD_LATENCY-1 and go to WAIT.
- WAIT:
  - Count down. When the counter is 0, capture reg_data_out into rsp_rdata and go to RESP.
  - With RD_LATENCY = 1, WAIT lasts one cycle and capture happens in the cycle after ISSUE.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err stay stable while rsp_ready is low.
  - On handshake, go to IDLE.
  - The earliest next accept is the cycle after the handshake (no same-cycle re-accept).
- reg_* outputs outside ISSUE: access_en = 0, wr_en = 0, thread_id = 0, data_in = 0. This avoids leaking stale data.
- Latency for a permitted read, accept cycle to rsp_valid: 2 + RD_LATENCY cycles. Permitted write: 2 cycles. Denied request: 1 cycle.
- Request inputs are ignored outside IDLE.
- A req_tid wider than the register's view is compared in full width; any set bit means denied.

Optional Feature:
- Macro: SECURE_REQ_AUDIT_EN.
- When defined, the block adds:
  - output last_denied_tid [TID_WIDTH-1:0], loaded with req_tid on every denied accept;
  - output audit_valid (1 bit), set on the first denial after reset and cleared only by rst.
  - Both reset to 0.
- When not defined:
  - these ports do not exist;
  - all other behaviour is identical, including denied_cnt.

Test Plan:
- Permitted write, then read: RD_LATENCY = 1, tid = 0, write 0xDEADBEEF, then read.
  -> Write: one reg_access_en pulse with wr_en = 1 and data_in = 0xDEADBEEF; response has rsp_err = 0.
  -> Read: response rsp_rdata = 0xDEADBEEF, rsp_valid exactly 3 cycles after accept.
- Denied request: tid = 5, write 0x1234.
  -> No reg_access_en pulse; rsp_valid the cycle after accept; rsp_err = 1; rsp_rdata = 0; denied_cnt = 1.
  -> With SECURE_REQ_AUDIT_EN: last_denied_tid = 5, audit_valid = 1.
- Backpressure: hold rsp_ready = 0 for 4 cycles on a read returning 0xA5A5A5A5.
  -> rsp_valid and data stay stable; req_ready = 0 throughout; a new req_valid is not accepted until the cycle after the handshake.
- Counter saturation: CNT_WIDTH = 4, issue 17 denied requests.
  -> denied_cnt stops at 15.
- Reset mid-operation: RD_LATENCY = 3, assert rst during WAIT.
  -> Next cycle: state IDLE, rsp_valid = 0, reg_* = 0, denied_cnt = 0; no response is delivered afterwards.
- Latency check: RD_LATENCY = 4, read with tid = 0.
  -> reg_data_out is sampled 4 cycles after the ISSUE cycle; rsp_valid 6 cycles after accept.

Source files
------------

// File: rtl/secure_reg_requester.sv
// Initiator for the thread-gated secure register: one outstanding request, local privilege check.
// Define SECURE_REQ_AUDIT_EN to add the last_denied_tid / audit_valid audit outputs.
module secure_reg_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int TID_WIDTH  = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [TID_WIDTH-1:0]  req_tid,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  reg_access_en,
    output logic                  reg_wr_en,
    output logic [TID_WIDTH-1:0]  reg_thread_id,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [CNT_WIDTH-1:0]  denied_cnt
`ifdef SECURE_REQ_AUDIT_EN
    ,
    output logic [TID_WIDTH-1:0]  last_denied_tid,
    output logic                  audit_valid
`endif
);

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_reg, state_next;
    logic                  wr_reg;
    logic [TID_WIDTH-1:0]  tid_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [LAT_W-1:0]      lat_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  err_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  accept;
    logic                  denied;
    logic                  issue;

    assign accept = (state_reg == IDLE) && req_valid;
    // Full-width compare: any set bit in the thread id is unprivileged.
    assign denied = accept && (req_tid != '0);
    assign issue  = (state_reg == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = (req_tid == '0) ? ISSUE : RESP;
            ISSUE:   state_next = wr_reg ? RESP : WAIT;
            WAIT:    if (lat_reg == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_reg    <= 1'b0;
            tid_reg   <= '0;
            wdata_reg <= '0;
            lat_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        wr_reg    <= req_wr;
                        tid_reg   <= req_tid;
                        wdata_reg <= req_wdata;
                        rdata_reg <= '0;
                        err_reg   <= denied;
                    end
                    if (denied && !(&cnt_reg)) begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                    end
                end
                ISSUE: begin
                    if (!wr_reg) lat_reg <= LAT_W'(RD_LATENCY - 1);
                end
                WAIT: begin
                    if (lat_reg == '0) rdata_reg <= reg_data_out;
                    else               lat_reg   <= lat_reg - LAT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SECURE_REQ_AUDIT_EN
    logic [TID_WIDTH-1:0] last_tid_reg;
    logic                 audit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_tid_reg <= '0;
            audit_reg    <= 1'b0;
        end else if (denied) begin
            last_tid_reg <= req_tid;
            audit_reg    <= 1'b1;
        end
    end

    assign last_denied_tid = last_tid_reg;
    assign audit_valid     = audit_reg;
`endif

    // Register-side outputs are forced to zero outside ISSUE so no stale data is exposed.
    assign req_ready     = (state_reg == IDLE);
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_rdata     = rdata_reg;
    assign rsp_err       = err_reg;
    assign reg_access_en = issue;
    assign reg_wr_en     = issue & wr_reg;
    assign reg_thread_id = issue ? tid_reg : '0;
    assign reg_data_in   = issue ? wdata_reg : '0;
    assign denied_cnt    = cnt_reg;

endmodule

// File: tb/tb_secure_reg_requester.sv
// Bench for secure_reg_requester: directed scenarios plus random traffic against a transaction-level model.
// Audit outputs are checked when SECURE_REQ_AUDIT_EN is defined.
module tb_secure_reg_requester;

    localparam int RD_LAT  = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_wr = 1'b0;
    logic [31:0]      req_tid = '0;
    logic [31:0]      req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             reg_access_en;
    logic             reg_wr_en;
    logic [31:0]      reg_thread_id;
    logic [31:0]      reg_data_in;
    logic [31:0]      reg_data_out = '0;
    logic [CNT_W-1:0] denied_cnt;
`ifdef SECURE_REQ_AUDIT_EN
    logic [31:0]      last_denied_tid;
    logic             audit_valid;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Fake register: stores on write strobes, presents read data only in the cycle it is due.
    logic [31:0] reg_mem = '0;
    logic [31:0] rd_hold = '0;
    int          issue_cyc = -100;

    // Transaction-level reference model.
    logic [31:0] exp_mem = '0;
    int          cnt_model = 0;
    logic [31:0] exp_last_tid = '0;
    logic        exp_audit = 1'b0;

    secure_reg_requester #(
        .DATA_WIDTH(32),
        .TID_WIDTH(32),
        .RD_LATENCY(RD_LAT),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_tid(req_tid),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .reg_access_en(reg_access_en),
        .reg_wr_en(reg_wr_en),
        .reg_thread_id(reg_thread_id),
        .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out),
        .denied_cnt(denied_cnt)
`ifdef SECURE_REQ_AUDIT_EN
        ,
        .last_denied_tid(last_denied_tid),
        .audit_valid(audit_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (reg_access_en === 1'b1) begin
            if (reg_wr_en) begin
                reg_mem = reg_data_in;
            end else begin
                issue_cyc = cyc;
                rd_hold   = reg_mem;
            end
        end
        reg_data_out = (cyc == issue_cyc + RD_LAT) ? rd_hold : $urandom;
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_reg_outs"}, {reg_access_en, reg_wr_en, reg_thread_id, reg_data_in}, 0);
        chk({tag, "_denied_cnt"}, denied_cnt, 0);
`ifdef SECURE_REQ_AUDIT_EN
        chk({tag, "_audit"}, {last_denied_tid, audit_valid}, 0);
`endif
    endtask

    // One full request/response; junk stays on the request port while busy and through the handshake.
    task automatic txn(input logic wr, input logic [31:0] tid, input logic [31:0] wdata, input int hold);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          lat;
        int          pulses;
        exp_err = (tid != 0);
        exp_lat = exp_err ? 1 : (wr ? 2 : 2 + RD_LAT);
        exp_rd  = (exp_err || wr) ? 32'h0 : exp_mem;
        chk("req_ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_tid   = tid;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        step();
        if (!exp_err && wr) exp_mem = wdata;
        if (exp_err) begin
            if (cnt_model < CNT_MAX) cnt_model++;
            exp_last_tid = tid;
            exp_audit    = 1'b1;
        end
        lat    = 1;
        pulses = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            chk("req_ready_busy", req_ready, 0);
            if (reg_access_en === 1'b1) begin
                pulses++;
                chk("issue_wr_en", reg_wr_en, wr);
                chk("issue_tid", reg_thread_id, 0);
                chk("issue_data_in", reg_data_in, wdata);
            end else begin
                chk("reg_quiet", {reg_wr_en, reg_thread_id, reg_data_in}, 0);
            end
            req_wr    = $urandom;
            req_tid   = $urandom;
            req_wdata = $urandom;
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("access_pulses", pulses, exp_err ? 0 : 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("denied_cnt", denied_cnt, cnt_model);
`ifdef SECURE_REQ_AUDIT_EN
        chk("last_denied_tid", last_denied_tid, exp_last_tid);
        chk("audit_valid", audit_valid, exp_audit);
`endif
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, exp_rd);
            chk("bp_rsp_err", rsp_err, exp_err);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_reg_access_en", reg_access_en, 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);
        chk("post_hs_no_access", reg_access_en, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] t;

        rst = 1'b1;
        step();
        check_idle_state("reset_held");
        step();
        rst = 1'b0;
        step();
        check_idle_state("after_reset");

        // Permitted write then read-back.
        txn(1'b1, 32'h0, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h0, 32'h0, 0);

        // Denied write, then a denial on the top bit alone.
        txn(1'b1, 32'h5, 32'h0000_1234, 0);
        txn(1'b0, 32'h8000_0000, 32'h0, 1);

        // Backpressure on a read.
        txn(1'b1, 32'h0, 32'hA5A5_A5A5, 2);
        txn(1'b0, 32'h0, 32'h0, 4);

        // Drive the denied counter into saturation.
        for (int i = 0; i < 17; i++) begin
            t = $urandom_range(1, 1000);
            txn($urandom_range(0, 1), t, $urandom, 0);
        end
        chk("cnt_saturated", denied_cnt, CNT_MAX);

        // Reset during WAIT drops the in-flight read.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_tid   = 32'h0;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_wait_busy", req_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt_model    = 0;
        exp_last_tid = '0;
        exp_audit    = 1'b0;
        check_idle_state("reset_mid_wait");
        for (int i = 0; i < RD_LAT + 4; i++) begin
            step();
            chk("no_rsp_after_reset", {rsp_valid, reg_access_en}, 0);
        end

        // Random mix of permitted and denied traffic.
        for (int i = 0; i < 30; i++) begin
            t = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            txn($urandom_range(0, 1), t, $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
